// File: rtl/control_unit_if.sv
// Control-unit <-> datapath strobe bundle for the Mini SRC core.
// The control unit is the master: it consumes ir/status and drives every strobe.
interface control_unit_if #(
  parameter int OPW = 5
);
  logic [31:0]    ir;
  logic           con_ff;
  logic           mem_ready;
  logic           stop;
  logic           gra;
  logic           grb;
  logic           grc;
  logic           rin;
  logic           rout;
  logic           baout;
  logic           pcout;
  logic           pcin;
  logic           incpc;
  logic           marin;
  logic           mdrin;
  logic           mdrout;
  logic           irin;
  logic           yin;
  logic           zin;
  logic           zlowout;
  logic           cout;
  logic           conin;
  logic           read;
  logic           write;
  logic [OPW-1:0] alu_op;
  logic           run;

  modport master (
    input  ir, con_ff, mem_ready, stop,
    output gra, grb, grc, rin, rout, baout,
    output pcout, pcin, incpc, marin, mdrin,
    output mdrout, irin, yin, zin, zlowout,
    output cout, conin, read, write,
    output alu_op, run
  );

  modport slave (
    output ir, con_ff, mem_ready, stop,
    input  gra, grb, grc, rin, rout, baout,
    input  pcout, pcin, incpc, marin, mdrin,
    input  mdrout, irin, yin, zin, zlowout,
    input  cout, conin, read, write,
    input  alu_op, run
  );
endinterface

// File: rtl/control_unit.sv
// Mini SRC multi-cycle control unit: Moore FSM stepping fetch/decode/execute,
// one instruction at a time, strobes decoded from state and the loaded ir.
module control_unit #(
  parameter int OPW     = 5,
  parameter bit RST_RUN = 1'b1
) (
  input  logic          clock,
  input  logic          reset_n,
  control_unit_if.master cu
);

  localparam logic [OPW-1:0] OP_LD     = OPW'(5'b00000);
  localparam logic [OPW-1:0] OP_LDI    = OPW'(5'b00001);
  localparam logic [OPW-1:0] OP_ST     = OPW'(5'b00010);
  localparam logic [OPW-1:0] OP_ADD    = OPW'(5'b00011);
  localparam logic [OPW-1:0] OP_ALU_HI = OPW'(5'b01010);
  localparam logic [OPW-1:0] OP_ADDI   = OPW'(5'b01011);
  localparam logic [OPW-1:0] OP_IMM_HI = OPW'(5'b01101);
  localparam logic [OPW-1:0] OP_BR     = OPW'(5'b10010);
  localparam logic [OPW-1:0] OP_JR     = OPW'(5'b10011);
  localparam logic [OPW-1:0] OP_HALT   = OPW'(5'b11011);

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3,
    S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_NOP, C_ALU, C_IMM, C_LDI, C_LD,
    C_ST, C_BR, C_JR, C_HALT
  } cls_t;

  state_t         state;
  cls_t           cls;
  logic           run_q;
  logic           t1_hold;
  logic [OPW-1:0] op;
  logic           unused_ir;

  assign op        = cu.ir[31 -: OPW];
  assign unused_ir = ^cu.ir[31-OPW:0];

  always_comb begin
    cls = C_NOP;
    unique case (1'b1)
      (op == OP_LD):   cls = C_LD;
      (op == OP_LDI):  cls = C_LDI;
      (op == OP_ST):   cls = C_ST;
      (op >= OP_ADD && op <= OP_ALU_HI):
        cls = C_ALU;
      (op >= OP_ADDI && op <= OP_IMM_HI):
        cls = C_IMM;
      (op == OP_BR):   cls = C_BR;
      (op == OP_JR):   cls = C_JR;
      (op == OP_HALT): cls = C_HALT;
      default:         cls = C_NOP;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_RST;
      run_q   <= 1'b0;
      t1_hold <= 1'b0;
    end else begin
      // pcin fires only on the first cycle of a (possibly stalled) T1
      t1_hold <= (state == S_T1);
      case (state)
        S_RST: begin
          state <= S_T0;
          run_q <= RST_RUN;
        end
        S_T0: begin
          if (cu.stop) begin
            state <= S_HALT;
            run_q <= 1'b0;
          end else begin
            state <= S_T1;
          end
        end
        S_T1: if (cu.mem_ready) state <= S_T2;
        S_T2: state <= S_T3;
        S_T3: begin
          case (cls)
            C_NOP, C_JR: state <= S_T0;
            C_HALT: begin
              state <= S_HALT;
              run_q <= 1'b0;
            end
            default: state <= S_T4;
          endcase
        end
        S_T4: state <= S_T5;
        S_T5: begin
          if (cls == C_LD || cls == C_ST || cls == C_BR)
            state <= S_T6;
          else
            state <= S_T0;
        end
        S_T6: begin
          case (cls)
            C_LD:    if (cu.mem_ready) state <= S_T7;
            C_ST:    state <= S_T7;
            default: state <= S_T0;
          endcase
        end
        S_T7: begin
          if (cls != C_ST || cu.mem_ready)
            state <= S_T0;
        end
        S_HALT: begin
          state <= S_HALT;
          run_q <= 1'b0;
        end
        default: state <= S_RST;
      endcase
    end
  end

  always_comb begin
    cu.gra     = 1'b0;
    cu.grb     = 1'b0;
    cu.grc     = 1'b0;
    cu.rin     = 1'b0;
    cu.rout    = 1'b0;
    cu.baout   = 1'b0;
    cu.pcout   = 1'b0;
    cu.pcin    = 1'b0;
    cu.incpc   = 1'b0;
    cu.marin   = 1'b0;
    cu.mdrin   = 1'b0;
    cu.mdrout  = 1'b0;
    cu.irin    = 1'b0;
    cu.yin     = 1'b0;
    cu.zin     = 1'b0;
    cu.zlowout = 1'b0;
    cu.cout    = 1'b0;
    cu.conin   = 1'b0;
    cu.read    = 1'b0;
    cu.write   = 1'b0;
    cu.alu_op  = '0;
    cu.run     = run_q;
    case (state)
      S_T0: begin
        cu.pcout = 1'b1;
        cu.marin = 1'b1;
        cu.incpc = 1'b1;
        cu.zin   = 1'b1;
      end
      S_T1: begin
        cu.zlowout = 1'b1;
        cu.pcin    = !t1_hold;
        cu.read    = 1'b1;
        cu.mdrin   = 1'b1;
      end
      S_T2: begin
        cu.mdrout = 1'b1;
        cu.irin   = 1'b1;
      end
      S_T3: begin
        case (cls)
          C_ALU, C_IMM: begin
            cu.grb  = 1'b1;
            cu.rout = 1'b1;
            cu.yin  = 1'b1;
          end
          C_LDI, C_LD, C_ST: begin
            cu.grb   = 1'b1;
            cu.baout = 1'b1;
            cu.yin   = 1'b1;
          end
          C_BR: begin
            cu.gra   = 1'b1;
            cu.rout  = 1'b1;
            cu.conin = 1'b1;
          end
          C_JR: begin
            cu.gra  = 1'b1;
            cu.rout = 1'b1;
            cu.pcin = 1'b1;
          end
          default: ;
        endcase
      end
      S_T4: begin
        case (cls)
          C_ALU: begin
            cu.grc    = 1'b1;
            cu.rout   = 1'b1;
            cu.zin    = 1'b1;
            cu.alu_op = op;
          end
          C_IMM: begin
            cu.cout   = 1'b1;
            cu.zin    = 1'b1;
            cu.alu_op = op;
          end
          C_LDI, C_LD, C_ST: begin
            cu.cout   = 1'b1;
            cu.zin    = 1'b1;
            cu.alu_op = OP_ADD;
          end
          C_BR: begin
            cu.pcout = 1'b1;
            cu.yin   = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        case (cls)
          C_ALU, C_IMM, C_LDI: begin
            cu.zlowout = 1'b1;
            cu.gra     = 1'b1;
            cu.rin     = 1'b1;
          end
          C_LD, C_ST: begin
            cu.zlowout = 1'b1;
            cu.marin   = 1'b1;
          end
          C_BR: begin
            cu.cout   = 1'b1;
            cu.zin    = 1'b1;
            cu.alu_op = OP_ADD;
          end
          default: ;
        endcase
      end
      S_T6: begin
        case (cls)
          C_LD: begin
            cu.read  = 1'b1;
            cu.mdrin = 1'b1;
          end
          C_ST: begin
            cu.gra   = 1'b1;
            cu.rout  = 1'b1;
            cu.mdrin = 1'b1;
          end
          C_BR: begin
            cu.zlowout = 1'b1;
            cu.pcin    = cu.con_ff;
          end
          default: ;
        endcase
      end
      S_T7: begin
        case (cls)
          C_LD: begin
            cu.mdrout = 1'b1;
            cu.gra    = 1'b1;
            cu.rin    = 1'b1;
          end
          C_ST: cu.write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle expected strobe vectors
// go into a scoreboard queue, a negedge monitor pops and compares.
module tb_control_unit;

  typedef logic [25:0] vec_t;

  typedef struct {
    vec_t  v;
    string n;
  } exp_t;

  localparam vec_t GRA  = vec_t'(1) << 25;
  localparam vec_t GRB  = vec_t'(1) << 24;
  localparam vec_t GRC  = vec_t'(1) << 23;
  localparam vec_t RIN  = vec_t'(1) << 22;
  localparam vec_t ROUT = vec_t'(1) << 21;
  localparam vec_t BAO  = vec_t'(1) << 20;
  localparam vec_t PCO  = vec_t'(1) << 19;
  localparam vec_t PCIN = vec_t'(1) << 18;
  localparam vec_t INCP = vec_t'(1) << 17;
  localparam vec_t MARI = vec_t'(1) << 16;
  localparam vec_t MDRI = vec_t'(1) << 15;
  localparam vec_t MDRO = vec_t'(1) << 14;
  localparam vec_t IRIN = vec_t'(1) << 13;
  localparam vec_t YIN  = vec_t'(1) << 12;
  localparam vec_t ZIN  = vec_t'(1) << 11;
  localparam vec_t ZLO  = vec_t'(1) << 10;
  localparam vec_t COUT = vec_t'(1) << 9;
  localparam vec_t CONI = vec_t'(1) << 8;
  localparam vec_t RD   = vec_t'(1) << 7;
  localparam vec_t WR   = vec_t'(1) << 6;
  localparam vec_t RUN  = vec_t'(1) << 5;
  localparam vec_t A_ADD = vec_t'(5'b00011);

  localparam vec_t E_T0  = PCO | MARI | INCP | ZIN | RUN;
  localparam vec_t E_T1  = ZLO | PCIN | RD | MDRI | RUN;
  localparam vec_t E_T1W = ZLO | RD | MDRI | RUN;
  localparam vec_t E_T2  = MDRO | IRIN | RUN;
  localparam vec_t E_ADR = GRB | BAO | YIN | RUN;
  localparam vec_t E_AC  = COUT | ZIN | RUN | A_ADD;
  localparam vec_t E_WB  = ZLO | GRA | RIN | RUN;

  logic clock;
  logic reset_n;
  int   compared;
  int   mismatched;
  int   t0_seen;
  bit   rnd_phase;
  exp_t exp_q[$];

  control_unit_if cu ();

  control_unit #(.OPW(5), .RST_RUN(1'b1)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .cu      (cu)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic vec_t actual();
    return {cu.gra, cu.grb, cu.grc, cu.rin, cu.rout,
            cu.baout, cu.pcout, cu.pcin, cu.incpc,
            cu.marin, cu.mdrin, cu.mdrout, cu.irin,
            cu.yin, cu.zin, cu.zlowout, cu.cout,
            cu.conin, cu.read, cu.write, cu.run,
            cu.alu_op};
  endfunction

  function automatic logic [31:0] mk(input logic [4:0] op);
    return {op, 4'd1, 4'd2, 4'd3, 15'd0};
  endfunction

  always @(negedge clock) begin
    exp_t e;
    vec_t a;
    a = actual();
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compared++;
      if (a !== e.v) begin
        mismatched++;
        $display("FAIL %s: got %h expected %h", e.n, a, e.v);
      end
    end
    if (reset_n) begin
      compared += 3;
      if ($countones({cu.gra, cu.grb, cu.grc}) > 1) begin
        mismatched++;
        $display("FAIL onehot_sel: got %h expected <=1 set", a);
      end
      if ($countones({cu.rout, cu.baout, cu.pcout, cu.mdrout,
                      cu.zlowout, cu.cout}) > 1) begin
        mismatched++;
        $display("FAIL bus_driver: got %h expected <=1 driver", a);
      end
      if (cu.read && cu.write) begin
        mismatched++;
        $display("FAIL rd_wr: got %h expected not both", a);
      end
    end
    if (rnd_phase && cu.pcout && cu.marin) t0_seen++;
  end

  task automatic push(input vec_t e, input string n);
    exp_q.push_back('{v: e, n: n});
  endtask

  task automatic step(input vec_t e, input logic mr, input logic cf,
                      input logic st, input string n);
    @(posedge clock);
    #1;
    cu.mem_ready = mr;
    cu.con_ff    = cf;
    cu.stop      = st;
    push(e, n);
  endtask

  task automatic fetch(input logic [31:0] ins, input int waits,
                       input logic cf, input string n);
    step(E_T0, 1'b1, cf, 1'b0, {n, "_T0"});
    cu.ir = ins;
    if (waits == 0) begin
      step(E_T1, 1'b1, cf, 1'b0, {n, "_T1"});
    end else begin
      step(E_T1, 1'b0, cf, 1'b0, {n, "_T1"});
      for (int i = 1; i < waits; i++)
        step(E_T1W, 1'b0, cf, 1'b0, {n, "_T1w"});
      step(E_T1W, 1'b1, cf, 1'b0, {n, "_T1w"});
    end
    step(E_T2, 1'b1, cf, 1'b0, {n, "_T2"});
  endtask

  task automatic s(input vec_t e, input string n);
    step(e, 1'b1, 1'b0, 1'b0, n);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(26'd0, 1'b1, 1'b0, 1'b0, "reset_hold");
    reset_n = 1'b1;
  endtask

  task automatic run_br(input logic cf, input string n);
    fetch(mk(5'b10010), 0, cf, n);
    step(GRA | ROUT | CONI | RUN, 1'b1, cf, 1'b0, {n, "_T3"});
    step(PCO | YIN | RUN, 1'b1, cf, 1'b0, {n, "_T4"});
    step(E_AC & ~ZIN | COUT | ZIN, 1'b1, cf, 1'b0, {n, "_T5"});
    step(cf ? (ZLO | PCIN | RUN) : (ZLO | RUN),
         1'b1, cf, 1'b0, {n, "_T6"});
  endtask

  initial begin
    logic [4:0] ops [9];
    ops = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100,
            5'b01011, 5'b10010, 5'b10011, 5'b11010};
    compared   = 0;
    mismatched = 0;
    t0_seen    = 0;
    rnd_phase  = 1'b0;
    reset_n    = 1'b0;
    cu.ir        = 32'd0;
    cu.con_ff    = 1'b0;
    cu.mem_ready = 1'b0;
    cu.stop      = 1'b0;

    s(26'd0, "reset0");
    s(26'd0, "reset1");
    reset_n = 1'b1;

    fetch(mk(5'b00011), 0, 1'b0, "add");
    s(GRB | ROUT | YIN | RUN, "add_T3");
    s(GRC | ROUT | ZIN | RUN | vec_t'(5'b00011), "add_T4");
    s(E_WB, "add_T5");

    fetch(mk(5'b01011), 2, 1'b0, "addi");
    s(GRB | ROUT | YIN | RUN, "addi_T3");
    s(COUT | ZIN | RUN | vec_t'(5'b01011), "addi_T4");
    s(E_WB, "addi_T5");

    fetch(mk(5'b00001), 0, 1'b0, "ldi");
    s(E_ADR, "ldi_T3");
    s(E_AC, "ldi_T4");
    s(E_WB, "ldi_T5");

    fetch(mk(5'b00000), 0, 1'b0, "ld");
    s(E_ADR, "ld_T3");
    s(E_AC, "ld_T4");
    s(ZLO | MARI | RUN, "ld_T5");
    step(RD | MDRI | RUN, 1'b0, 1'b0, 1'b0, "ld_T6a");
    step(RD | MDRI | RUN, 1'b0, 1'b0, 1'b0, "ld_T6b");
    step(RD | MDRI | RUN, 1'b0, 1'b0, 1'b0, "ld_T6c");
    step(RD | MDRI | RUN, 1'b1, 1'b0, 1'b0, "ld_T6d");
    s(MDRO | GRA | RIN | RUN, "ld_T7");

    fetch(mk(5'b00010), 1, 1'b0, "st");
    s(E_ADR, "st_T3");
    s(E_AC, "st_T4");
    s(ZLO | MARI | RUN, "st_T5");
    s(GRA | ROUT | MDRI | RUN, "st_T6");
    step(WR | RUN, 1'b0, 1'b0, 1'b0, "st_T7a");
    step(WR | RUN, 1'b1, 1'b0, 1'b0, "st_T7b");

    run_br(1'b0, "br0");
    run_br(1'b1, "br1");

    fetch(mk(5'b10011), 0, 1'b0, "jr");
    s(GRA | ROUT | PCIN | RUN, "jr_T3");

    fetch(mk(5'b11010), 0, 1'b0, "nop");
    s(RUN, "nop_T3");

    fetch(mk(5'b11111), 0, 1'b0, "undef");
    s(RUN, "undef_T3");

    fetch(mk(5'b00011), 0, 1'b0, "addrst");
    s(GRB | ROUT | YIN | RUN, "addrst_T3");
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    push(26'd0, "rst_mid_T4");
    s(26'd0, "rst_mid_hold");
    reset_n = 1'b1;
    fetch(mk(5'b11010), 0, 1'b0, "after_rst");
    s(RUN, "after_rst_T3");

    fetch(mk(5'b11011), 0, 1'b0, "halt");
    s(RUN, "halt_T3");
    s(26'd0, "halt_H0");
    s(26'd0, "halt_H1");
    do_reset();

    step(E_T0, 1'b1, 1'b0, 1'b1, "stop_T0");
    s(26'd0, "stop_H0");
    s(26'd0, "stop_H1");
    do_reset();

    rnd_phase = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(posedge clock);
      #1;
      cu.mem_ready = 1'($urandom_range(0, 1));
      cu.con_ff    = 1'($urandom_range(0, 1));
      cu.stop      = 1'b0;
      if (cu.pcout && cu.marin)
        cu.ir = {ops[$urandom_range(0, 8)], 27'($urandom)};
    end
    rnd_phase = 1'b0;
    @(negedge clock);
    compared++;
    if (t0_seen < 20) begin
      mismatched++;
      $display("FAIL rnd_progress: got %0d T0s required >=20", t0_seen);
    end
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL queue_drain: got %0d left required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule
